frame_src_gen: RTL

//  Frame-buffer video source. Reads one frame of pixels from a dual-port RAM read port.

---
 rtl/vid_pkg.sv | 33 +++
 rtl/vid_pipe_dly.sv | 29 ++
 rtl/frame_src_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/vid_pkg.sv
// Shared types, default 1080p timing and small width helpers for the frame-buffer video source.
package vid_pkg;

    localparam int unsigned DEF_DW      = 8;
    localparam int unsigned DEF_AW      = 21;
    localparam int unsigned DEF_H_ACT   = 1920;
    localparam int unsigned DEF_V_ACT   = 1080;
    localparam int unsigned DEF_H_BLANK = 280;
    localparam int unsigned DEF_V_LEAD  = 16;
    localparam int unsigned DEF_V_TAIL  = 16;
    localparam int unsigned DEF_RD_LAT  = 2;

    typedef logic [DEF_DW-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        LINE,
        HBLK,
        TAIL,
        DRAIN
    } src_state_t;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vid_pipe_dly.sv
// Fixed-depth shift register that realigns address-phase raster strobes with RAM read data.
module vid_pipe_dly #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_src_gen.sv
// Frame-buffer video source: reads one frame from RAM and emits it as a hvalid/vvalid/dout raster.
// Macro FRAME_SRC_PATTERN_EN replaces RAM reads with a diagonal ramp pattern at identical timing.
module frame_src_gen
    import vid_pkg::*;
#(
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned AW      = DEF_AW,
    parameter int unsigned H_ACT   = DEF_H_ACT,
    parameter int unsigned V_ACT   = DEF_V_ACT,
    parameter int unsigned H_BLANK = DEF_H_BLANK,
    parameter int unsigned V_LEAD  = DEF_V_LEAD,
    parameter int unsigned V_TAIL  = DEF_V_TAIL,
    parameter int unsigned RD_LAT  = DEF_RD_LAT
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          start,
    output logic          busy,
    output logic          frame_done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          hvalid,
    output logic          vvalid,
    output logic [DW-1:0] dout
);

    localparam int unsigned PW = cnt_width(H_ACT);
    localparam int unsigned LW = cnt_width(V_ACT);
    localparam int unsigned BW = cnt_width(max_u(max_u(V_LEAD, H_BLANK), max_u(V_TAIL, RD_LAT)));

    if (longint'(H_ACT) * longint'(V_ACT) > (longint'(1) << AW)) begin : g_chk_aw
        $error("frame_src_gen: H_ACT*V_ACT does not fit in AW address bits");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_chk_lat
        $error("frame_src_gen: RD_LAT must be 1..4");
    end
    if (H_BLANK < 1 || V_LEAD < 1 || V_TAIL < 1 || H_ACT < 1 || V_ACT < 1) begin : g_chk_tim
        $error("frame_src_gen: timing parameters must be at least 1");
    end

    src_state_t    state_q, state_d;
    logic [BW-1:0] blk_cnt_q, blk_cnt_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          done_q, done_d;

    logic          pix_last, line_last;
    logic          hvalid_a, vvalid_a;

    assign pix_last  = (pix_cnt_q == PW'(H_ACT - 1));
    assign line_last = (line_cnt_q == LW'(V_ACT - 1));

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            blk_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            addr_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_cnt_q  <= blk_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        blk_cnt_d  = blk_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        addr_d     = addr_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The frame_done cycle still counts as busy, so a start there is dropped.
                if (start && !done_q) begin
                    state_d    = LEAD;
                    blk_cnt_d  = '0;
                    pix_cnt_d  = '0;
                    line_cnt_d = '0;
                    addr_d     = '0;
                end
            end
            LEAD: begin
                if (blk_cnt_q == BW'(V_LEAD - 1)) begin
                    state_d   = LINE;
                    pix_cnt_d = '0;
                end else begin
                    blk_cnt_d = blk_cnt_q + BW'(1);
                end
            end
            LINE: begin
                if (pix_last) begin
                    state_d   = HBLK;
                    blk_cnt_d = '0;
                    // Hold on the final pixel so the address never wraps inside a frame.
                    if (!line_last) begin
                        addr_d = addr_q + AW'(1);
                    end
                end else begin
                    pix_cnt_d = pix_cnt_q + PW'(1);
                    addr_d    = addr_q + AW'(1);
                end
            end
            HBLK: begin
                if (blk_cnt_q == BW'(H_BLANK - 1)) begin
                    blk_cnt_d = '0;
                    if (line_last) begin
                        state_d = TAIL;
                    end else begin
                        state_d    = LINE;
                        pix_cnt_d  = '0;
                        line_cnt_d = line_cnt_q + LW'(1);
                    end
                end else begin
                    blk_cnt_d = blk_cnt_q + BW'(1);
                end
            end
            TAIL: begin
                if (blk_cnt_q == BW'(V_TAIL - 1)) begin
                    state_d   = DRAIN;
                    blk_cnt_d = '0;
                    addr_d    = '0;
                end else begin
                    blk_cnt_d = blk_cnt_q + BW'(1);
                end
            end
            DRAIN: begin
                // Wait for the delay line to empty before reporting completion.
                if (blk_cnt_q == BW'(RD_LAT - 1)) begin
                    state_d   = IDLE;
                    blk_cnt_d = '0;
                    done_d    = 1'b1;
                end else begin
                    blk_cnt_d = blk_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign hvalid_a   = (state_q == LINE);
    assign vvalid_a   = (state_q == LEAD) || (state_q == LINE) ||
                        (state_q == HBLK) || (state_q == TAIL);
    assign busy       = (state_q != IDLE) || done_q;
    assign frame_done = done_q;
    assign rd_addr    = addr_q;

`ifdef FRAME_SRC_PATTERN_EN
    logic [DW-1:0] pat_a, pat_dly;
    logic          unused_rd_data;

    assign unused_rd_data = ^rd_data;
    assign rd_en          = 1'b0;
    assign pat_a          = hvalid_a ? (DW'(pix_cnt_q) + DW'(line_cnt_q)) : '0;

    vid_pipe_dly #(
        .WIDTH (DW + 2),
        .DEPTH (RD_LAT)
    ) u_dly (
        .clk   (clk),
        .rst_b (rst_b),
        .din   ({vvalid_a, hvalid_a, pat_a}),
        .dout  ({vvalid, hvalid, pat_dly})
    );

    assign dout = hvalid ? pat_dly : '0;
`else
    assign rd_en = hvalid_a;

    vid_pipe_dly #(
        .WIDTH (2),
        .DEPTH (RD_LAT)
    ) u_dly (
        .clk   (clk),
        .rst_b (rst_b),
        .din   ({vvalid_a, hvalid_a}),
        .dout  ({vvalid, hvalid})
    );

    assign dout = hvalid ? rd_data : '0;
`endif

endmodule
